// File: rtl/wb_slave_decoder.sv
// Wishbone single-master to four-slave decoder.
// The upper two address bits pick the slave. The request is latched on
// acceptance and held steady while the slave works on it. The access
// finishes with an ack pulse, a timeout error pulse, or a silent abort.
module wb_slave_decoder #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          m_cyc_i,
    input  logic          m_stb_i,
    input  logic          m_we_i,
    input  logic [31:0]   m_adr_i,
    input  logic [31:0]   m_dat_i,
    input  logic [3:0]    m_sel_i,
    output logic [31:0]   m_dat_o,
    output logic          m_ack_o,
    output logic          m_err_o,
    output logic [3:0]    s_cyc_o,
    output logic [3:0]    s_stb_o,
    output logic          s_we_o,
    output logic [31:0]   s_adr_o,
    output logic [31:0]   s_dat_o,
    output logic [3:0]    s_sel_o,
    input  logic [127:0]  s_dat_i,
    input  logic [3:0]    s_ack_i
);

    localparam logic [7:0] TO = 8'(TIMEOUT);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t      state, state_nx;
    logic [1:0]  idx;
    logic [7:0]  cnt;
    logic        sel_ack;
    logic [31:0] sel_dat;
    logic        to_hit;

    // Only the addressed slave's ack and data lane matter; others are ignored.
    assign sel_ack = s_ack_i[idx];
    assign sel_dat = s_dat_i[{idx, 5'd0} +: 32];
    assign to_hit  = (cnt + 8'd1) == TO;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next state and slave-side strobes. The master dropping cyc beats
    // everything, and an ack beats a timeout in the same cycle.
    always_comb begin
        state_nx = state;
        s_cyc_o  = 4'b0000;
        s_stb_o  = 4'b0000;
        case (state)
            IDLE: if (m_cyc_i && m_stb_i) state_nx = BUSY;
            BUSY: begin
                s_cyc_o = 4'b0001 << idx;
                s_stb_o = 4'b0001 << idx;
                if (!m_cyc_i)                state_nx = IDLE;
                else if (sel_ack || to_hit)  state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Latch the request fields on acceptance; they stay put through BUSY.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx     <= 2'd0;
            s_we_o  <= 1'b0;
            s_adr_o <= 32'd0;
            s_dat_o <= 32'd0;
            s_sel_o <= 4'd0;
        end else if (state == IDLE && m_cyc_i && m_stb_i) begin
            idx     <= m_adr_i[31:30];
            s_we_o  <= m_we_i;
            s_adr_o <= m_adr_i;
            s_dat_o <= m_dat_i;
            s_sel_o <= m_sel_i;
        end
    end

    // Timeout counter: cleared on acceptance, counts BUSY cycles with no ack.
    always_ff @(posedge clk) begin
        if (rst)                                    cnt <= 8'd0;
        else if (state == IDLE)                     cnt <= 8'd0;
        else if (state == BUSY && !sel_ack)         cnt <= cnt + 8'd1;
    end

    // Completion pulses land in DONE. Read data is captured on every ack,
    // including writes, and is left alone on error or abort.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_ack_o <= 1'b0;
            m_err_o <= 1'b0;
            m_dat_o <= 32'd0;
        end else begin
            m_ack_o <= (state == BUSY) && m_cyc_i && sel_ack;
            m_err_o <= (state == BUSY) && m_cyc_i && !sel_ack && to_hit;
            if (state == BUSY && m_cyc_i && sel_ack) m_dat_o <= sel_dat;
        end
    end

endmodule

// File: tb/tb_wb_slave_decoder.sv
// Randomized bench for wb_slave_decoder. Two instances with TIMEOUT=4 and
// TIMEOUT=3 share the same stimulus. A transaction-level model predicts,
// for each one, how long the strobe stays up and how the access ends.
module tb_wb_slave_decoder;

    logic         clk = 1'b0;
    logic         rst;
    logic         m_cyc_i, m_stb_i, m_we_i;
    logic [31:0]  m_adr_i, m_dat_i;
    logic [3:0]   m_sel_i;
    logic [127:0] s_dat_i;
    logic [3:0]   s_ack_i;

    logic [31:0]  dat_o  [2];
    logic         ack_o  [2];
    logic         err_o  [2];
    logic [3:0]   cyc_o  [2];
    logic [3:0]   stb_o  [2];
    logic         we_o   [2];
    logic [31:0]  adr_o  [2];
    logic [31:0]  sdat_o [2];
    logic [3:0]   sel_o  [2];

    int total = 0;
    int bad   = 0;
    int          to_val  [2] = '{4, 3};
    logic [31:0] exp_dat [2] = '{32'd0, 32'd0};

    always #5 clk = ~clk;

    wb_slave_decoder #(.TIMEOUT(4)) dut_a (
        .clk(clk), .rst(rst), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(dat_o[0]), .m_ack_o(ack_o[0]), .m_err_o(err_o[0]),
        .s_cyc_o(cyc_o[0]), .s_stb_o(stb_o[0]), .s_we_o(we_o[0]), .s_adr_o(adr_o[0]),
        .s_dat_o(sdat_o[0]), .s_sel_o(sel_o[0]), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i));

    wb_slave_decoder #(.TIMEOUT(3)) dut_b (
        .clk(clk), .rst(rst), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(dat_o[1]), .m_ack_o(ack_o[1]), .m_err_o(err_o[1]),
        .s_cyc_o(cyc_o[1]), .s_stb_o(stb_o[1]), .s_we_o(we_o[1]), .s_adr_o(adr_o[1]),
        .s_dat_o(sdat_o[1]), .s_sel_o(sel_o[1]), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Outcome of an access: the master abort is checked first, then the
    // slave ack, and the timeout fires at the end of BUSY cycle T.
    // kind: 0=abort, 1=ack, 2=err. len = number of cycles the strobe is up.
    task automatic model(input int t, input int ack_k, input int ab_k,
                         output int len, output int kind);
        len = t; kind = 2;
        for (int k = 1; k <= t; k++) begin
            if (ab_k == k)  begin len = k; kind = 0; return; end
            if (ack_k == k) begin len = k; kind = 1; return; end
        end
    endtask

    // One access. ack_k / ab_k / wr_k give the BUSY cycle (1-based) in which
    // the target ack, the cyc drop and a wrong-slave ack are driven (0 = never).
    task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input logic [127:0] sd,
                        input int ack_k, input int ab_k, input int wr_k, input int wr_s);
        int          len  [2];
        int          kind [2];
        int          i;
        logic [3:0]  oh;
        logic [31:0] slice;
        logic        busy;
        i     = int'(adr[31:30]);
        oh    = 4'(1 << i);
        slice = sd[i*32 +: 32];
        for (int d = 0; d < 2; d++) model(to_val[d], ack_k, ab_k, len[d], kind[d]);
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = we;
        m_adr_i = adr;  m_dat_i = dat;  m_sel_i = sel;
        s_dat_i = sd;   s_ack_i = 4'b0;
        @(posedge clk);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                busy = (k <= len[d]);
                if (k == len[d] + 1 && kind[d] == 1) exp_dat[d] = slice;
                chk("stb", 32'(stb_o[d]), busy ? 32'(oh) : 32'd0);
                chk("cyc", 32'(cyc_o[d]), busy ? 32'(oh) : 32'd0);
                chk("ack", 32'(ack_o[d]), 32'(k == len[d] + 1 && kind[d] == 1));
                chk("err", 32'(err_o[d]), 32'(k == len[d] + 1 && kind[d] == 2));
                chk("mdat", dat_o[d], exp_dat[d]);
                if (busy) begin
                    chk("s_we", 32'(we_o[d]), 32'(we));
                    chk("s_adr", adr_o[d], adr);
                    chk("s_dat", sdat_o[d], dat);
                    chk("s_sel", 32'(sel_o[d]), 32'(sel));
                end
            end
            m_stb_i = 1'b0;
            if (k == ab_k) m_cyc_i = 1'b0;
            s_ack_i = 4'b0;
            if (k == ack_k) s_ack_i[i] = 1'b1;
            if (k == wr_k)  s_ack_i[wr_s] = 1'b1;
        end
        @(negedge clk);
        m_cyc_i = 1'b0; s_ack_i = 4'b0;
    endtask

    // Reset arrives in BUSY together with the target's ack: the ack must be lost.
    task automatic rst_in_busy(input logic [31:0] adr);
        int i;
        i = int'(adr[31:30]);
        @(negedge clk);
        m_cyc_i = 1'b1; m_stb_i = 1'b1; m_we_i = 1'b0; m_adr_i = adr;
        s_dat_i = {4{32'hCAFE_F00D}};
        @(posedge clk);
        @(negedge clk); m_stb_i = 1'b0;
        @(negedge clk); rst = 1'b1; s_ack_i[i] = 1'b1;
        @(negedge clk); rst = 1'b0; s_ack_i = 4'b0; m_cyc_i = 1'b0;
        for (int d = 0; d < 2; d++) begin
            exp_dat[d] = 32'd0;
            chk("rst_stb", 32'(stb_o[d]), 32'd0);
            chk("rst_ack", 32'(ack_o[d]), 32'd0);
            chk("rst_err", 32'(err_o[d]), 32'd0);
            chk("rst_mdat", dat_o[d], 32'd0);
        end
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_ack2", 32'(ack_o[d]), 32'd0);
            chk("rst_err2", 32'(err_o[d]), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b1; m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
        m_adr_i = '0; m_dat_i = '0; m_sel_i = '0; s_dat_i = '0; s_ack_i = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            chk("r_stb", 32'(stb_o[d]), 32'd0);
            chk("r_cyc", 32'(cyc_o[d]), 32'd0);
            chk("r_ack", 32'(ack_o[d]), 32'd0);
            chk("r_err", 32'(err_o[d]), 32'd0);
            chk("r_mdat", dat_o[d], 32'd0);
            chk("r_adr", adr_o[d], 32'd0);
            chk("r_sdat", sdat_o[d], 32'd0);
            chk("r_we", 32'(we_o[d]), 32'd0);
            chk("r_sel", 32'(sel_o[d]), 32'd0);
        end

        // read from slave 2, ack in the first BUSY cycle
        xfer(1'b0, 32'h8000_0010, 32'h0, 4'hF, {32'h0, 32'hDEAD_BEEF, 64'h0}, 1, 0, 0, 0);
        // write to slave 0, ack after three cycles
        xfer(1'b1, 32'h0000_0004, 32'h1234_5678, 4'hF, {96'h0, 32'h0BAD_0001}, 3, 0, 0, 0);
        // slave 3 never acks: both instances time out
        xfer(1'b0, 32'hC000_0000, 32'h0, 4'h3, {32'h3333_3333, 96'h0}, 0, 0, 0, 0);
        // target slave 1 with a stray ack on slave 0, then the real ack
        xfer(1'b0, 32'h4000_0020, 32'h0, 4'hF, {64'h0, 32'h1111_2222, 32'h0}, 2, 0, 1, 0);
        // master drops cyc two cycles into BUSY
        xfer(1'b0, 32'h8000_0000, 32'h0, 4'hF, {128{1'b1}}, 0, 2, 0, 0);
        // ack on the third BUSY cycle collides with the TIMEOUT=3 instance
        xfer(1'b0, 32'h4000_0000, 32'h0, 4'hF, {64'h0, 32'h5A5A_A5A5, 32'h0}, 3, 0, 0, 0);
        // ack on the fourth cycle: late for TIMEOUT=3, just in time for TIMEOUT=4
        xfer(1'b1, 32'h0000_0100, 32'h7777_0000, 4'h1, {96'h0, 32'h0F0F_0F0F}, 4, 0, 0, 0);
        rst_in_busy(32'h8000_0040);

        for (int n = 0; n < 40; n++) begin
            logic [31:0] adr;
            int ab_k, wr_k, wr_s;
            adr  = $urandom;
            ab_k = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 4) : 0;
            wr_k = ($urandom_range(0, 1) == 0) ? $urandom_range(1, 6) : 0;
            wr_s = (int'(adr[31:30]) + 1 + $urandom_range(0, 2)) % 4;
            xfer(1'($urandom), adr, $urandom, 4'($urandom),
                 {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 6), ab_k, wr_k, wr_s);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
